// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and a system-ID slave.
// Signals: av_address (word select), av_read (strobe), av_waitrequest (stall), av_readdata (32-bit).
// Modports: master drives address/read; slave drives waitrequest/readdata.
interface sysid_checker_if;
   logic        av_address;
   logic        av_read;
   logic        av_waitrequest;
   logic [31:0] av_readdata;

   modport master (
      output av_address,
      output av_read,
      input  av_waitrequest,
      input  av_readdata
   );

   modport slave (
      input  av_address,
      input  av_read,
      output av_waitrequest,
      output av_readdata
   );
endinterface

// File: rtl/sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp) and compares both against expected values.
// Latency: start sampled -> done pulse in 3 cycles with a zero-wait slave; each stall cycle adds one.
// Backpressure: av_read/av_address are held while av_waitrequest=1; a read stalled TIMEOUT_CYCLES
// cycles is abandoned (timeout_err). start is ignored while busy or in FIN.
// Ports: clk, reset_n (async active-low), start, bus (master modport), busy, done, id_ok, ts_ok,
// pass, timeout_err, id_value, ts_value.
// Optional: define SYSID_CHECKER_PERIODIC_EN to re-run the check RECHECK_PERIOD cycles after each
// completed check.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd1368189285,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1327357851,
   parameter int          AUTO_START         = 1,
   parameter int          TIMEOUT_CYCLES     = 255
`ifdef SYSID_CHECKER_PERIODIC_EN
   ,
   parameter int          RECHECK_PERIOD     = 1000000
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   sysid_checker_if.master      bus,
   output logic                 busy,
   output logic                 done,
   output logic                 id_ok,
   output logic                 ts_ok,
   output logic                 pass,
   output logic                 timeout_err,
   output logic [31:0]          id_value,
   output logic [31:0]          ts_value
);

   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;

   localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYCLES[15:0];

   state_t      state;
   state_t      state_nxt;
   logic        rd_q;
   logic        addr_q;
   logic        auto_pend;
   logic [15:0] tmo_cnt;
   logic        accept;
   logic        stall;
   logic        tmo_hit;
   logic        recheck;
   logic        trigger;

   assign bus.av_read    = rd_q;
   assign bus.av_address = addr_q;

   assign accept  = rd_q & ~bus.av_waitrequest;
   assign stall   = rd_q &  bus.av_waitrequest;
   // Abort on the stalled cycle that brings the count to the limit, so av_read is
   // high for exactly TIMEOUT_CYCLES stalled cycles. An accept never counts as a stall.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && stall && ((tmo_cnt + 16'd1) == TMO_LIMIT);
   assign trigger = start | auto_pend | recheck;

   assign busy = (state == RD_ID) || (state == RD_TS);
   assign done = (state == FIN);
   assign pass = id_ok & ts_ok & ~timeout_err;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (trigger) state_nxt = RD_ID;
         RD_ID: begin
            if (accept)       state_nxt = RD_TS;
            else if (tmo_hit) state_nxt = FIN;
         end
         RD_TS: begin
            if (accept || tmo_hit) state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rd_q        <= 1'b0;
         addr_q      <= 1'b0;
         auto_pend   <= (AUTO_START != 0);
         tmo_cnt     <= 16'd0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= 32'd0;
         ts_value    <= 32'd0;
      end else begin
         state  <= state_nxt;
         // Strobes are registered from the next state so they line up with RD_ID/RD_TS.
         rd_q   <= (state_nxt == RD_ID) || (state_nxt == RD_TS);
         addr_q <= (state_nxt == RD_TS);
         // Auto-start only has meaning in the first cycle after reset release.
         auto_pend <= 1'b0;

         if (state == IDLE && state_nxt == RD_ID) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            tmo_cnt     <= 16'd0;
         end else if (state == RD_ID || state == RD_TS) begin
            if (accept) begin
               tmo_cnt <= 16'd0;
               if (state == RD_ID) begin
                  id_value <= bus.av_readdata;
                  id_ok    <= (bus.av_readdata == EXPECTED_ID);
               end else begin
                  ts_value <= bus.av_readdata;
                  ts_ok    <= (bus.av_readdata == EXPECTED_TIMESTAMP);
               end
            end else if (stall) begin
               if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
               if (tmo_hit) timeout_err <= 1'b1;
            end
         end
      end
   end

`ifdef SYSID_CHECKER_PERIODIC_EN
   localparam logic [31:0] PERIOD_LAST = RECHECK_PERIOD[31:0] - 32'd1;

   logic [31:0] period_cnt;
   logic        ran_once;

   assign recheck = (state == IDLE) && ran_once && (period_cnt == PERIOD_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt <= 32'd0;
         ran_once   <= 1'b0;
      end else if (state == FIN) begin
         period_cnt <= 32'd0;
         ran_once   <= 1'b1;
      end else if (start) begin
         period_cnt <= 32'd0;
      end else if (state == IDLE && ran_once && !recheck) begin
         period_cnt <= period_cnt + 32'd1;
      end
   end
`else
   assign recheck = 1'b0;
`endif

endmodule
